// File: rtl/definitions.sv
// Shared ALU definitions: opcode encodings and datapath width.
package definitions;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        LSH = 4'b0000,
        RSH = 4'b0001,
        AND = 4'b0010,
        OR  = 4'b0011,
        GEQ = 4'b1000,
        EQ  = 4'b1001,
        NEG = 4'b1010,
        ADD = 4'b1011,
        NEQ = 4'b1101
    } op_t;

endpackage

// File: rtl/alu_unit.sv
// 8-bit ALU with combinational result/Zero plus registered copies.
// Optional carry output when ALU_CARRY_EN is defined.
module alu_unit
    import definitions::*;
#(
    parameter int W = DATA_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic [3:0]   OP,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic [W-1:0] ResultReg,
    output logic         ZeroReg
`ifdef ALU_CARRY_EN
    ,
    output logic         Carry,
    output logic         CarryReg
`endif
);

    logic [W-1:0] sum;

    assign sum = InputA + InputB;

    always_comb begin
        Out = '0;
        case (op_t'(OP))
            LSH:     Out = {InputA[W-2:0], 1'b0};
            RSH:     Out = {1'b0, InputA[W-1:1]};
            AND:     Out = InputA & InputB;
            OR:      Out = InputA | InputB;
            GEQ:     Out = (InputA >= InputB) ? W'(1) : '0;
            EQ:      Out = (InputA == InputB) ? W'(1) : '0;
            NEG:     Out = (~InputA) + W'(1);
            ADD:     Out = sum;
            NEQ:     Out = (InputA != InputB) ? W'(1) : '0;
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

`ifdef ALU_CARRY_EN
    // A wrapped sum is smaller than either operand exactly when it carried.
    always_comb begin
        Carry = 1'b0;
        case (op_t'(OP))
            ADD:     Carry = (sum < InputA);
            LSH:     Carry = InputA[W-1];
            RSH:     Carry = InputA[0];
            default: Carry = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ResultReg <= '0;
            ZeroReg   <= 1'b1;
`ifdef ALU_CARRY_EN
            CarryReg  <= 1'b0;
`endif
        end else begin
            ResultReg <= Out;
            ZeroReg   <= Zero;
`ifdef ALU_CARRY_EN
            CarryReg  <= Carry;
`endif
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases, reset behaviour
// and randomized operations against an arithmetic reference model.
module tb_alu_unit;

    logic       Clk;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [3:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic [7:0] ResultReg;
    logic       ZeroReg;
`ifdef ALU_CARRY_EN
    logic       Carry;
    logic       CarryReg;
`endif

    int total = 0;
    int bad   = 0;

    alu_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InputA    (InputA),
        .InputB    (InputB),
        .OP        (OP),
        .Out       (Out),
        .Zero      (Zero),
        .ResultReg (ResultReg),
        .ZeroReg   (ZeroReg)
`ifdef ALU_CARRY_EN
        ,
        .Carry     (Carry),
        .CarryReg  (CarryReg)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int model_out(int a, int b, int op);
        case (op)
            0:       return (a * 2) % 256;
            1:       return a / 2;
            2:       return a & b;
            3:       return a | b;
            8:       return (a >= b) ? 1 : 0;
            9:       return (a == b) ? 1 : 0;
            10:      return (256 - a) % 256;
            11:      return (a + b) % 256;
            13:      return (a != b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int model_carry(int a, int b, int op);
        case (op)
            0:       return (a >= 128) ? 1 : 0;
            1:       return a % 2;
            11:      return (a + b > 255) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(int a, int b, int op);
        InputA = 8'(a);
        InputB = 8'(b);
        OP     = 4'(op);
        #1;
    endtask

    task automatic comb_chk(string tag, int a, int b, int op);
        int e;
        apply(a, b, op);
        e = model_out(a, b, op);
        chk({tag, "_out"}, 32'(Out), 32'(e));
        chk({tag, "_zero"}, 32'(Zero), 32'(e == 0));
`ifdef ALU_CARRY_EN
        chk({tag, "_carry"}, 32'(Carry), 32'(model_carry(a, b, op)));
`endif
    endtask

    initial begin
        int a, b, op, e, c;
        Reset  = 1'b1;
        InputA = '0;
        InputB = '0;
        OP     = '0;
        #2;
        chk("rst_result", 32'(ResultReg), 32'h00);
        chk("rst_zero", 32'(ZeroReg), 32'h1);
`ifdef ALU_CARRY_EN
        chk("rst_carry", 32'(CarryReg), 32'h0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        comb_chk("lsh_01", 8'h01, 8'h01, 0);
        chk("lsh_01_lit", 32'(Out), 32'h02);
        comb_chk("rsh_01", 8'h01, 8'h01, 1);
        chk("rsh_01_zero", 32'(Zero), 32'h1);
        comb_chk("lsh_81", 8'h81, 8'h00, 0);
        chk("lsh_81_lit", 32'(Out), 32'h02);
        comb_chk("rsh_81", 8'h81, 8'h00, 1);
        chk("rsh_81_lit", 32'(Out), 32'h40);
        comb_chk("and_11", 1, 1, 2);
        comb_chk("or_10", 1, 0, 3);
        comb_chk("and_f0", 8'hF0, 8'h0F, 2);
        chk("and_f0_zero", 32'(Zero), 32'h1);
        comb_chk("or_f0", 8'hF0, 8'h0F, 3);
        chk("or_f0_lit", 32'(Out), 32'hFF);
        comb_chk("geq_34", 3, 4, 8);
        comb_chk("geq_44", 4, 4, 8);
        chk("geq_44_lit", 32'(Out), 32'h01);
        comb_chk("eq_22", 2, 2, 9);
        comb_chk("neq_13", 1, 3, 13);
        comb_chk("neq_33", 3, 3, 13);
        comb_chk("neg_1", 1, 0, 10);
        chk("neg_1_lit", 32'(Out), 32'hFF);
        comb_chk("neg_0", 0, 0, 10);
        comb_chk("neg_80", 8'h80, 0, 10);
        chk("neg_80_lit", 32'(Out), 32'h80);
        comb_chk("add_11", 1, 1, 11);
        comb_chk("add_ff", 8'hFF, 1, 11);
        chk("add_ff_zero", 32'(Zero), 32'h1);
        comb_chk("unused_c", 8'h55, 8'h33, 12);
        comb_chk("unused_5", 8'h55, 8'h33, 5);

        // registered path and asynchronous reset
        @(negedge Clk);
        apply(1, 1, 11);
        @(posedge Clk);
        #1;
        chk("reg_add", 32'(ResultReg), 32'h02);
        chk("reg_add_zero", 32'(ZeroReg), 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_res", 32'(ResultReg), 32'h00);
        chk("async_rst_zero", 32'(ZeroReg), 32'h1);
        chk("async_rst_out", 32'(Out), 32'h02);
        @(posedge Clk);
        #1;
        chk("hold_rst_res", 32'(ResultReg), 32'h00);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("post_rst_res", 32'(ResultReg), 32'h00);
        @(posedge Clk);
        #1;
        chk("reload_res", 32'(ResultReg), 32'h02);
        chk("reload_zero", 32'(ZeroReg), 32'h0);

        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 15));
            comb_chk("rnd", a, b, op);
            e = model_out(a, b, op);
            c = model_carry(a, b, op);
            @(posedge Clk);
            #1;
            chk("rnd_reg", 32'(ResultReg), 32'(e));
            chk("rnd_zreg", 32'(ZeroReg), 32'(e == 0));
`ifdef ALU_CARRY_EN
            chk("rnd_creg", 32'(CarryReg), 32'(c));
`else
            if (c > 1) chk("rnd_cmodel", 32'(c), 32'h1);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
